// File: rtl/rf_ctrl_pkg.sv
// rf_ctrl_pkg: shared definitions for the register-file write-port control slice.
//   - Default widths for the writeback path (data, address, register count).
//   - grant_t: which requester owns the RF write port in a given cycle.
//   - REG_ZERO: hard-wired zero register; writes to it are acknowledged but dropped.
// Optional build macro used by this slice: RF_SB_CHECK_EN (see rf_scoreboard).
package rf_ctrl_pkg;

    localparam int unsigned DEF_DATA_W     = 16;
    localparam int unsigned DEF_ADDR_W     = 4;
    localparam int unsigned DEF_NUM_REGS   = 2 ** DEF_ADDR_W;
    localparam int unsigned DEF_STARVE_LIM = 4;

    typedef enum logic [1:0] {
        GNT_NONE,
        GNT_A,
        GNT_B
    } grant_t;

    localparam int unsigned REG_ZERO = 0;

endpackage

// File: rtl/rf_scoreboard.sv
// rf_scoreboard: per-register pending-write scoreboard for RAW hazard stalls.
//   Ports:
//     clk, rst_n          clock, asynchronous active-low reset
//     rsv_vld, rsv_addr   decode reserves a destination register (sets busy)
//     wr_en, wr_addr      a write was accepted this cycle (clears busy)
//     q0_addr, q1_addr    hazard query addresses
//     q0_busy, q1_busy    combinational query results (current busy state)
//     busy_vec            full scoreboard
//     err                 sticky protocol error
//   Build macro RF_SB_CHECK_EN: when defined, err flags WAW reservations and
//   writes to unreserved registers; when undefined, err is tied low.
module rf_scoreboard
    import rf_ctrl_pkg::*;
#(
    parameter int unsigned ADDR_W   = DEF_ADDR_W,
    parameter int unsigned NUM_REGS = 2 ** ADDR_W
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                rsv_vld,
    input  logic [ADDR_W-1:0]   rsv_addr,
    input  logic                wr_en,
    input  logic [ADDR_W-1:0]   wr_addr,
    input  logic [ADDR_W-1:0]   q0_addr,
    input  logic [ADDR_W-1:0]   q1_addr,
    output logic                q0_busy,
    output logic                q1_busy,
    output logic [NUM_REGS-1:0] busy_vec,
    output logic                err
);

    logic [NUM_REGS-1:0] busy;
    logic [NUM_REGS-1:0] busy_nxt;

    // Clear is applied before set so a same-edge reservation (younger) wins.
    always_comb begin
        busy_nxt = busy;
        for (int unsigned r = 1; r < NUM_REGS; r++) begin
            if (wr_en && wr_addr == ADDR_W'(r))
                busy_nxt[r] = 1'b0;
            if (rsv_vld && rsv_addr == ADDR_W'(r))
                busy_nxt[r] = 1'b1;
        end
        busy_nxt[REG_ZERO] = 1'b0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            busy <= '0;
        else
            busy <= busy_nxt;
    end

    // Queries see the pre-edge state, so a register being written this
    // cycle still reads busy; the RF bypass covers the following read.
    assign q0_busy  = busy[q0_addr];
    assign q1_busy  = busy[q1_addr];
    assign busy_vec = busy;

`ifdef RF_SB_CHECK_EN
    logic err_q;
    logic waw_err;
    logic unres_err;

    always_comb begin
        waw_err   = rsv_vld && (rsv_addr != ADDR_W'(REG_ZERO)) && busy[rsv_addr]
                    && !(wr_en && wr_addr == rsv_addr);
        unres_err = wr_en && (wr_addr != ADDR_W'(REG_ZERO)) && !busy[wr_addr];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            err_q <= 1'b0;
        else if (waw_err || unres_err)
            err_q <= 1'b1;
    end

    assign err = err_q;
`else
    assign err = 1'b0;
`endif

endmodule

// File: rtl/rf_wb_arbiter.sv
// rf_wb_arbiter: owns the single RF write port and arbitrates ALU (A) and
// load-unit (B) writebacks, with anti-starvation for B, plus a scoreboard.
//   Ports:
//     clk, rst_n                    clock, asynchronous active-low reset
//     a_vld/a_addr/a_data, a_rdy    ALU writeback request / combinational accept
//     b_vld/b_addr/b_data, b_rdy    load writeback request / combinational accept
//     rsv_vld, rsv_addr             destination reservation from decode
//     q0_addr/q0_busy, q1_addr/q1_busy  RAW hazard queries
//     we, dst_addr, dst             registered RF write port
//     busy_vec                      scoreboard contents
//     err                           sticky scoreboard protocol error
//   Build macro RF_SB_CHECK_EN enables the err checks inside rf_scoreboard.
module rf_wb_arbiter
    import rf_ctrl_pkg::*;
#(
    parameter int unsigned DATA_W     = DEF_DATA_W,
    parameter int unsigned ADDR_W     = DEF_ADDR_W,
    parameter int unsigned STARVE_LIM = DEF_STARVE_LIM,
    parameter int unsigned NUM_REGS   = 2 ** ADDR_W
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                a_vld,
    input  logic [ADDR_W-1:0]   a_addr,
    input  logic [DATA_W-1:0]   a_data,
    output logic                a_rdy,
    input  logic                b_vld,
    input  logic [ADDR_W-1:0]   b_addr,
    input  logic [DATA_W-1:0]   b_data,
    output logic                b_rdy,
    input  logic                rsv_vld,
    input  logic [ADDR_W-1:0]   rsv_addr,
    input  logic [ADDR_W-1:0]   q0_addr,
    input  logic [ADDR_W-1:0]   q1_addr,
    output logic                q0_busy,
    output logic                q1_busy,
    output logic                we,
    output logic [ADDR_W-1:0]   dst_addr,
    output logic [DATA_W-1:0]   dst,
    output logic [NUM_REGS-1:0] busy_vec,
    output logic                err
);

    // STARVE_LIM is limited to 1..15, so a 4-bit counter always suffices.
    localparam int unsigned CNT_W = 4;

    grant_t             gnt;
    logic [CNT_W-1:0]   starve_cnt;
    logic               wr_en;
    logic [ADDR_W-1:0]  wr_addr;
    logic [DATA_W-1:0]  wr_data;

    always_comb begin
        gnt = GNT_NONE;
        if (b_vld && (!a_vld || starve_cnt == CNT_W'(STARVE_LIM)))
            gnt = GNT_B;
        else if (a_vld)
            gnt = GNT_A;
    end

    assign a_rdy   = (gnt == GNT_A);
    assign b_rdy   = (gnt == GNT_B);
    assign wr_en   = a_rdy || b_rdy;
    assign wr_addr = b_rdy ? b_addr : a_addr;
    assign wr_data = b_rdy ? b_data : a_data;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            starve_cnt <= '0;
        else if (b_vld && !b_rdy) begin
            if (starve_cnt != CNT_W'(STARVE_LIM))
                starve_cnt <= starve_cnt + 1'b1;
        end else
            starve_cnt <= '0;
    end

    // Writes to the zero register complete the handshake but never reach the RF.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            we       <= 1'b0;
            dst_addr <= '0;
            dst      <= '0;
        end else begin
            we <= 1'b0;
            if (wr_en && wr_addr != ADDR_W'(REG_ZERO)) begin
                we       <= 1'b1;
                dst_addr <= wr_addr;
                dst      <= wr_data;
            end
        end
    end

    rf_scoreboard #(
        .ADDR_W   (ADDR_W),
        .NUM_REGS (NUM_REGS)
    ) u_sb (
        .clk      (clk),
        .rst_n    (rst_n),
        .rsv_vld  (rsv_vld),
        .rsv_addr (rsv_addr),
        .wr_en    (wr_en),
        .wr_addr  (wr_addr),
        .q0_addr  (q0_addr),
        .q1_addr  (q1_addr),
        .q0_busy  (q0_busy),
        .q1_busy  (q1_busy),
        .busy_vec (busy_vec),
        .err      (err)
    );

endmodule

// File: tb/tb_rf_wb_arbiter.sv
// tb_rf_wb_arbiter: directed table-driven bench for rf_wb_arbiter
// (DATA_W=16, ADDR_W=4, STARVE_LIM=4), plus hand-written multi-cycle sequences.
module tb_rf_wb_arbiter;

`ifdef RF_SB_CHECK_EN
    localparam bit CHK = 1'b1;
`else
    localparam bit CHK = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        a_vld = 1'b0, b_vld = 1'b0, rsv_vld = 1'b0;
    logic [3:0]  a_addr = '0, b_addr = '0, rsv_addr = '0, q0_addr = '0, q1_addr = '0;
    logic [15:0] a_data = '0, b_data = '0;
    logic        a_rdy, b_rdy, q0_busy, q1_busy, we, err;
    logic [3:0]  dst_addr;
    logic [15:0] dst;
    logic [15:0] busy_vec;

    int total = 0;
    int bad   = 0;

    rf_wb_arbiter #(
        .DATA_W     (16),
        .ADDR_W     (4),
        .STARVE_LIM (4)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .a_vld    (a_vld),
        .a_addr   (a_addr),
        .a_data   (a_data),
        .a_rdy    (a_rdy),
        .b_vld    (b_vld),
        .b_addr   (b_addr),
        .b_data   (b_data),
        .b_rdy    (b_rdy),
        .rsv_vld  (rsv_vld),
        .rsv_addr (rsv_addr),
        .q0_addr  (q0_addr),
        .q1_addr  (q1_addr),
        .q0_busy  (q0_busy),
        .q1_busy  (q1_busy),
        .we       (we),
        .dst_addr (dst_addr),
        .dst      (dst),
        .busy_vec (busy_vec),
        .err      (err)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    typedef struct {
        logic        a_vld;
        logic [3:0]  a_addr;
        logic [15:0] a_data;
        logic        b_vld;
        logic [3:0]  b_addr;
        logic [15:0] b_data;
        logic        rsv_vld;
        logic [3:0]  rsv_addr;
        logic [3:0]  q0;
        logic [3:0]  q1;
        // same-cycle expectations
        logic        x_a_rdy;
        logic        x_b_rdy;
        logic        x_q0;
        logic        x_q1;
        // after the next rising edge
        logic        x_we;
        logic [3:0]  x_dst_addr;
        logic [15:0] x_dst;
        logic [15:0] x_busy;
    } vec_t;

    vec_t vecs[12];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic idle_inputs();
        a_vld = 1'b0; b_vld = 1'b0; rsv_vld = 1'b0;
        a_addr = '0; b_addr = '0; rsv_addr = '0;
        a_data = '0; b_data = '0;
    endtask

    function automatic vec_t mk(input logic av, input logic [3:0] aa, input logic [15:0] ad,
                                input logic bv, input logic [3:0] ba, input logic [15:0] bd,
                                input logic rv, input logic [3:0] ra,
                                input logic [3:0] q0, input logic [3:0] q1,
                                input logic xar, input logic xbr, input logic xq0, input logic xq1,
                                input logic xwe, input logic [3:0] xda, input logic [15:0] xd,
                                input logic [15:0] xb);
        vec_t v;
        v.a_vld = av; v.a_addr = aa; v.a_data = ad;
        v.b_vld = bv; v.b_addr = ba; v.b_data = bd;
        v.rsv_vld = rv; v.rsv_addr = ra; v.q0 = q0; v.q1 = q1;
        v.x_a_rdy = xar; v.x_b_rdy = xbr; v.x_q0 = xq0; v.x_q1 = xq1;
        v.x_we = xwe; v.x_dst_addr = xda; v.x_dst = xd; v.x_busy = xb;
        return v;
    endfunction

    // One contention cycle: drive both requesters at addr 0, check grants.
    task automatic contend(input string name, input logic exp_a, input logic exp_b);
        a_vld = 1'b1; a_addr = 4'd0; a_data = 16'h00AA;
        b_vld = 1'b1; b_addr = 4'd0; b_data = 16'h00BB;
        #1;
        chk({name, ".a_rdy"}, {31'd0, a_rdy}, {31'd0, exp_a});
        chk({name, ".b_rdy"}, {31'd0, b_rdy}, {31'd0, exp_b});
        @(posedge clk);
        @(negedge clk);
    endtask

    initial begin
        //            A: vld addr data     B: vld addr data    rsv       q0 q1  ardy brdy q0b q1b  we da  dst       busy
        vecs[0]  = mk(0, 0, 16'h0000,     0, 0, 16'h0000,     1, 3,     3, 0,  0, 0, 0, 0,      0, 0, 16'h0000, 16'h0008);
        vecs[1]  = mk(0, 0, 16'h0000,     0, 0, 16'h0000,     1, 5,     3, 5,  0, 0, 1, 0,      0, 0, 16'h0000, 16'h0028);
        vecs[2]  = mk(1, 3, 16'hBEEF,     0, 0, 16'h0000,     1, 7,     3, 7,  1, 0, 1, 0,      1, 3, 16'hBEEF, 16'h00A0);
        vecs[3]  = mk(0, 0, 16'h0000,     0, 0, 16'h0000,     0, 0,     3, 7,  0, 0, 0, 1,      0, 3, 16'hBEEF, 16'h00A0);
        vecs[4]  = mk(0, 0, 16'h0000,     1, 5, 16'h1111,     0, 0,     5, 7,  0, 1, 1, 1,      1, 5, 16'h1111, 16'h0080);
        vecs[5]  = mk(0, 0, 16'h0000,     1, 0, 16'h1234,     0, 0,     0, 5,  0, 1, 0, 0,      0, 5, 16'h1111, 16'h0080);
        vecs[6]  = mk(1, 7, 16'h5555,     0, 0, 16'h0000,     1, 9,     7, 9,  1, 0, 1, 0,      1, 7, 16'h5555, 16'h0200);
        vecs[7]  = mk(1, 9, 16'h6666,     0, 0, 16'h0000,     1, 9,     9, 7,  1, 0, 1, 0,      1, 9, 16'h6666, 16'h0200);
        vecs[8]  = mk(1, 9, 16'h7777,     0, 0, 16'h0000,     0, 0,     9, 0,  1, 0, 1, 0,      1, 9, 16'h7777, 16'h0000);
        vecs[9]  = mk(0, 0, 16'h0000,     0, 0, 16'h0000,     1, 2,     2, 9,  0, 0, 0, 0,      0, 9, 16'h7777, 16'h0004);
        vecs[10] = mk(1, 2, 16'hAAAA,     1, 4, 16'hCCCC,     1, 4,     2, 4,  1, 0, 1, 0,      1, 2, 16'hAAAA, 16'h0010);
        vecs[11] = mk(0, 0, 16'h0000,     1, 4, 16'hCCCC,     0, 0,     4, 2,  0, 1, 1, 0,      1, 4, 16'hCCCC, 16'h0000);

        // Reset state while held in reset.
        #3;
        chk("rst.we", {31'd0, we}, 32'd0);
        chk("rst.dst_addr", {28'd0, dst_addr}, 32'd0);
        chk("rst.dst", {16'd0, dst}, 32'd0);
        chk("rst.busy_vec", {16'd0, busy_vec}, 32'd0);
        chk("rst.err", {31'd0, err}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 12; i++) begin
            a_vld = vecs[i].a_vld; a_addr = vecs[i].a_addr; a_data = vecs[i].a_data;
            b_vld = vecs[i].b_vld; b_addr = vecs[i].b_addr; b_data = vecs[i].b_data;
            rsv_vld = vecs[i].rsv_vld; rsv_addr = vecs[i].rsv_addr;
            q0_addr = vecs[i].q0; q1_addr = vecs[i].q1;
            #1;
            chk($sformatf("v%0d.a_rdy", i), {31'd0, a_rdy}, {31'd0, vecs[i].x_a_rdy});
            chk($sformatf("v%0d.b_rdy", i), {31'd0, b_rdy}, {31'd0, vecs[i].x_b_rdy});
            chk($sformatf("v%0d.q0_busy", i), {31'd0, q0_busy}, {31'd0, vecs[i].x_q0});
            chk($sformatf("v%0d.q1_busy", i), {31'd0, q1_busy}, {31'd0, vecs[i].x_q1});
            @(posedge clk);
            #1;
            chk($sformatf("v%0d.we", i), {31'd0, we}, {31'd0, vecs[i].x_we});
            chk($sformatf("v%0d.dst_addr", i), {28'd0, dst_addr}, {28'd0, vecs[i].x_dst_addr});
            chk($sformatf("v%0d.dst", i), {16'd0, dst}, {16'd0, vecs[i].x_dst});
            chk($sformatf("v%0d.busy_vec", i), {16'd0, busy_vec}, {16'd0, vecs[i].x_busy});
            chk($sformatf("v%0d.err", i), {31'd0, err}, 32'd0);
            @(negedge clk);
        end
        idle_inputs();

        // Contention at addr 0 (no RF writes, no scoreboard effects): 4:1 pattern.
        for (int i = 0; i < 10; i++)
            contend($sformatf("cont%0d", i), (i % 5) != 4, (i % 5) == 4);
        chk("cont.we", {31'd0, we}, 32'd0);
        chk("cont.busy_vec", {16'd0, busy_vec}, 32'd0);

        // Withdrawal: B refused twice, then drops vld; the counter restarts.
        contend("wd0", 1'b1, 1'b0);
        contend("wd1", 1'b1, 1'b0);
        b_vld = 1'b0;
        #1;
        chk("wd.a_only", {31'd0, a_rdy}, 32'd1);
        @(posedge clk);
        @(negedge clk);
        for (int i = 0; i < 5; i++)
            contend($sformatf("wdc%0d", i), i != 4, i == 4);
        idle_inputs();

        // Unreserved write to reg 7.
        a_vld = 1'b1; a_addr = 4'd7; a_data = 16'h0777;
        @(posedge clk);
        #1;
        chk("unres.we", {31'd0, we}, 32'd1);
        chk("unres.dst_addr", {28'd0, dst_addr}, 32'd7);
        chk("unres.err", {31'd0, err}, {31'd0, CHK});
        @(negedge clk);
        idle_inputs();
        @(posedge clk);
        #1;
        chk("unres.err_sticky", {31'd0, err}, {31'd0, CHK});
        @(negedge clk);

        // Asynchronous reset in the middle of a cycle with we=1.
        rsv_vld = 1'b1; rsv_addr = 4'd6;
        @(negedge clk);
        rsv_addr = 4'd8;
        @(negedge clk);
        rsv_vld = 1'b0;
        a_vld = 1'b1; a_addr = 4'd6; a_data = 16'h6E6E;
        @(posedge clk);
        #1;
        chk("pre_rst.we", {31'd0, we}, 32'd1);
        chk("pre_rst.busy_vec", {16'd0, busy_vec}, 32'h0100);
        #1;
        rst_n = 1'b0;
        #1;
        chk("arst.we", {31'd0, we}, 32'd0);
        chk("arst.dst", {16'd0, dst}, 32'd0);
        chk("arst.busy_vec", {16'd0, busy_vec}, 32'd0);
        chk("arst.err", {31'd0, err}, 32'd0);
        idle_inputs();
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        chk("post_rst.we", {31'd0, we}, 32'd0);
        chk("post_rst.dst_addr", {28'd0, dst_addr}, 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
